count_bcd_conv: RTL and testbench
=================================

Name: count_bcd_conv

Overview:
- Downstream consumer of the 8-bit up/down counter value.
- Converts each accepted binary sample to packed BCD digits with an iterative shift-add-3 (double-dabble) datapath, one bit per clock.
- Feeds the display/monitor stage through a valid/ready handshake on both sides, with output hold under backpressure.

Parameters:
- WIDTH, 8, binary input width in bits.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1. Elaboration fails with $error if it does not.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- din  input  WIDTH  binary sample (counter value).
- din_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept din this cycle.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 (ones) is in [3:0].
- out_valid  output  1  bcd holds a completed conversion.
- out_ready  input  1  downstream accepts bcd this cycle.
- busy  output  1  conversion in progress.

Behaviour:
- Reset: rst sampled high at a clk edge forces the following, regardless of state:
  - state=IDLE, bcd=0, out_valid=0, busy=0, internal shift/bit counters=0.
  - in_ready=0 while rst is high.
- Reset applies mid-conversion and mid-hold; any partial result is discarded.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On an edge with din_valid=1: capture din into the shift register, clear the BCD scratch, load bit counter=WIDTH, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge, in one cycle: every scratch digit >=5 gets +3 (4-bit add, no carry out), then the {scratch, shift reg} pair shifts left by 1 and the counter decrements.
  - When the counter reaches 0 (after exactly WIDTH shift edges), write the scratch to bcd, set out_valid=1, go to HOLD.
- HOLD:
  - out_valid=1, busy=0, in_ready=0.
  - bcd is stable until the handshake completes.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - No same-cycle re-accept.
- Latency: acceptance at edge E0 leads to out_valid high after edge E0+WIDTH (8 cycles by default).
- Minimum accept-to-accept spacing: WIDTH+2 cycles.
- din/din_valid while not in IDLE: ignored, not captured. Upstream must hold the value if it needs it converted.
- out_ready while out_valid=0: ignored.
- Boundary values:
  - din=0 gives bcd=0x000.
  - din=2^WIDTH-1 (255) gives 0x255.
  - No overflow is possible given the DIGITS constraint.
- bcd holds its last result after the handshake until the next conversion completes.

Optional Feature:
- Macro: COUNT_BCD_SKIP_DUP_EN.
- Defined:
  - Block keeps last_val (WIDTH bits) and a last_ok flag, both cleared by rst.
  - Case A: in IDLE, din_valid=1, last_ok=1, din==last_val. The sample is consumed (in_ready was 1), state stays IDLE, out_valid stays 0, bcd is unchanged.
  - Case B: any other accepted din converts normally and updates last_val, with last_ok<=1 at capture.
- Not defined:
  - No last_val register.
  - Every accepted sample is converted and presented.

Test Plan:
- Reset, then din=98 with din_valid pulsed 1 cycle, out_ready=1 -> in_ready drops the next cycle; out_valid rises exactly 8 cycles after acceptance with bcd=0x098; in_ready returns 1 cycle after the handshake.
- Sweep din = 0, 10, 99, 100, 255 -> bcd = 0x000, 0x010, 0x099, 0x100, 0x255.
- din=14 with out_ready held 0 for 20 cycles -> out_valid and bcd=0x014 stay constant, in_ready stays 0; raising out_ready for 1 cycle completes the handshake.
- Start a conversion of 200 and assert rst at the 4th SHIFT cycle -> next cycle bcd=0, out_valid=0, busy=0. After release, converting 37 gives 0x037.
- din_valid held high with din changing during SHIFT/HOLD -> only the value present at the IDLE acceptance edge is converted.
- With COUNT_BCD_SKIP_DUP_EN: send 50, 50, 51 -> exactly two out_valid events, 0x050 then 0x051. Without the macro: three events.

Source files
------------

// File: rtl/count_bcd_conv_if.sv
// Valid/ready bundle between the counter source, the BCD converter and the display stage.
// The converter takes the slave modport; the producer/consumer side takes master.
interface count_bcd_conv_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) ();
    logic [WIDTH-1:0]    din;
    logic                din_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport slave (
        input  din, din_valid, out_ready,
        output in_ready, bcd, out_valid, busy
    );

    modport master (
        output din, din_valid, out_ready,
        input  in_ready, bcd, out_valid, busy
    );
endinterface

// File: rtl/count_bcd_conv.sv
// Iterative binary-to-BCD converter (double dabble, one bit per clock) with valid/ready on both sides.
// Optional macro COUNT_BCD_SKIP_DUP_EN: drop a sample equal to the last converted one.
module count_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    count_bcd_conv_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_IN = (64'd1 << WIDTH) - 64'd1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    if (pow10(DIGITS) <= MAX_IN) begin : g_digits_check
        $error("count_bcd_conv: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [BCD_W-1:0] adj;
    logic             skip;

`ifdef COUNT_BCD_SKIP_DUP_EN
    logic [WIDTH-1:0] last_val_q, last_val_d;
    logic             last_ok_q, last_ok_d;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        adj         = scratch_q;
        skip        = 1'b0;
`ifdef COUNT_BCD_SKIP_DUP_EN
        last_val_d  = last_val_q;
        last_ok_d   = last_ok_q;
        skip        = last_ok_q && (bus.din == last_val_q);
`endif

        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (bus.din_valid && !skip) begin
                    shreg_d   = bus.din;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
`ifdef COUNT_BCD_SKIP_DUP_EN
                    last_val_d = bus.din;
                    last_ok_d  = 1'b1;
`endif
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = {adj, shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // NOTE: blocking assignments here, so bcd_d sees the scratch value just shifted in this cycle.
                    bcd_d       = scratch_d;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath is small, so every register including bcd is reset; partial results never leak out.
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            scratch_q   <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef COUNT_BCD_SKIP_DUP_EN
            last_val_q  <= '0;
            last_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef COUNT_BCD_SKIP_DUP_EN
            last_val_q  <= last_val_d;
            last_ok_q   <= last_ok_d;
`endif
        end
    end

    // in_ready follows rst directly so nothing is offered as accepted while reset is held.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.bcd       = bcd_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_count_bcd_conv.sv
// Scoreboard bench for count_bcd_conv: stimulus pushes expected BCD, a negedge monitor pops on each handshake.
// Honours COUNT_BCD_SKIP_DUP_EN the same way the design does.
module tb_count_bcd_conv;
    logic clk = 1'b0;
    logic rst;

    count_bcd_conv_if #(.WIDTH(8), .DIGITS(3)) bus ();

    count_bcd_conv #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_ev     = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next rising edge when both valid and ready are high now.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_ev++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.bcd), 32'hFFFF_FFFF);
            end else begin
                check("bcd_out", 32'(bus.bcd), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            step();
            n++;
        end
        check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 30) begin
            step();
            n++;
        end
        check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic send(input logic [7:0] val, input logic [11:0] exp, input bit expect_out);
        wait_ready();
        bus.out_ready = 1'b1;
        bus.din       = val;
        bus.din_valid = 1'b1;
        if (expect_out) exp_q.push_back(exp);
        step();
        bus.din_valid = 1'b0;
        if (expect_out) begin
            wait_valid();
            step();
        end else begin
            step();
            check("dup_stays_idle", 32'(bus.in_ready), 32'd1);
            check("dup_no_valid", 32'(bus.out_valid), 32'd0);
            check("dup_bcd_kept", 32'(bus.bcd), 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev0;
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // 98 with latency checks: out_valid exactly 8 edges after acceptance.
        bus.din       = 8'd98;
        bus.din_valid = 1'b1;
        exp_q.push_back(12'h098);
        step();
        bus.din_valid = 1'b0;
        check("accept_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("accept_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            step();
            check("latency_early_valid", 32'(bus.out_valid), 32'd0);
        end
        step();
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("latency_bcd", 32'(bus.bcd), 32'h098);
        check("hold_busy", 32'(bus.busy), 32'd0);
        step();
        check("post_hs_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_hs_bcd_kept", 32'(bus.bcd), 32'h098);

        // Sweep including both boundaries.
        send(8'd0,   12'h000, 1'b1);
        send(8'd10,  12'h010, 1'b1);
        send(8'd99,  12'h099, 1'b1);
        send(8'd100, 12'h100, 1'b1);
        send(8'd255, 12'h255, 1'b1);

        // Backpressure: result held stable for 20 cycles.
        wait_ready();
        bus.out_ready = 1'b0;
        bus.din       = 8'd14;
        bus.din_valid = 1'b1;
        exp_q.push_back(12'h014);
        step();
        bus.din_valid = 1'b0;
        wait_valid();
        for (int k = 0; k < 20; k++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_bcd", 32'(bus.bcd), 32'h014);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release", 32'(bus.out_valid), 32'd0);

        // Reset during the 4th SHIFT cycle of a 200 conversion.
        wait_ready();
        bus.din       = 8'd200;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("midrst_bcd", 32'(bus.bcd), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        send(8'd37, 12'h037, 1'b1);

        // din changes while busy: only the value at the accepting edge counts.
        wait_ready();
        bus.out_ready = 1'b0;
        bus.din       = 8'd123;
        bus.din_valid = 1'b1;
        exp_q.push_back(12'h123);
        step();
        for (int k = 0; k < 30 && !bus.out_valid; k++) begin
            bus.din = bus.din + 8'd7;
            step();
        end
        check("chg_valid", 32'(bus.out_valid), 32'd1);
        bus.din_valid = 1'b0;
        step();
        bus.out_ready = 1'b1;
        step();
        step();
        check("chg_no_reaccept", 32'(bus.busy), 32'd0);

        // Duplicate suppression (or not, in the default build).
        ev0 = n_ev;
        send(8'd50, 12'h050, 1'b1);
`ifdef COUNT_BCD_SKIP_DUP_EN
        send(8'd50, 12'h050, 1'b0);
`else
        send(8'd50, 12'h050, 1'b1);
`endif
        send(8'd51, 12'h051, 1'b1);
        repeat (3) step();
`ifdef COUNT_BCD_SKIP_DUP_EN
        check("dup_events", 32'(n_ev - ev0), 32'd2);
`else
        check("dup_events", 32'(n_ev - ev0), 32'd3);
`endif
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
